// File: rtl/pcfg_pkg.sv
// Shared definitions for the pcfg_bank register bank: per-bit access types
// and the mask-priority decode used by every register slice.
package pcfg_pkg;

    typedef enum logic [1:0] {
        ACC_RW    = 2'd0,
        ACC_W1C   = 2'd1,
        ACC_PULSE = 2'd2,
        ACC_RO    = 2'd3
    } acc_t;

    // Overlapping masks resolve as W1C > PULSE > RW; a bit in no mask is RO.
    function automatic acc_t acc_type(input logic rw, input logic w1c, input logic pulse);
        acc_t t;
        if (w1c) begin
            t = ACC_W1C;
        end else if (pulse) begin
            t = ACC_PULSE;
        end else if (rw) begin
            t = ACC_RW;
        end else begin
            t = ACC_RO;
        end
        return t;
    endfunction

endpackage

// File: rtl/pcfg_reg.sv
// One WIDTH-bit config/status register; each bit behaves as RW, W1C, PULSE
// or RO according to its mask bits.
module pcfg_reg
    import pcfg_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}},
    parameter logic [WIDTH-1:0] RW_MASK     = {WIDTH{1'b0}},
    parameter logic [WIDTH-1:0] W1C_MASK    = {WIDTH{1'b0}},
    parameter logic [WIDTH-1:0] PULSE_MASK  = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [WIDTH-1:0] wd,
    input  logic [WIDTH-1:0] hw_in,
    output logic [WIDTH-1:0] val
);

    // Only bits that actually resolve to RW take a non-zero reset value.
    localparam logic [WIDTH-1:0] RST_Q = RESET_VALUE & RW_MASK & ~W1C_MASK & ~PULSE_MASK;

    logic [WIDTH-1:0] reg_d;
    logic [WIDTH-1:0] reg_q;

    // Per-bit next state and visible value; a hardware set beats a same-cycle clear.
    always_comb begin
        reg_d = reg_q;
        val   = reg_q;
        for (int i = 0; i < WIDTH; i++) begin
            case (acc_type(RW_MASK[i], W1C_MASK[i], PULSE_MASK[i]))
                ACC_RW: begin
                    if (we) begin
                        reg_d[i] = wd[i];
                    end else begin
                        reg_d[i] = reg_q[i];
                    end
                end
                ACC_W1C: begin
                    if (hw_in[i]) begin
                        reg_d[i] = 1'b1;
                    end else if (we && wd[i]) begin
                        reg_d[i] = 1'b0;
                    end else begin
                        reg_d[i] = reg_q[i];
                    end
                end
                ACC_PULSE: begin
                    reg_d[i] = we & wd[i];
                end
                ACC_RO: begin
                    reg_d[i] = 1'b0;
                    val[i]   = hw_in[i];
                end
                default: begin
                    reg_d[i] = 1'b0;
                    val[i]   = 1'b0;
                end
            endcase
        end
    end

    // Register state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_q <= RST_Q;
        end else begin
            reg_q <= reg_d;
        end
    end

endmodule

// File: rtl/pcfg_bank.sv
// Bank of NREG config/status registers behind a registered microprocessor
// port, with a registered interrupt from the sticky W1C bits.
module pcfg_bank
    import pcfg_pkg::*;
#(
    parameter int                    WIDTH       = 8,
    parameter int                    NREG        = 4,
    parameter int                    AW          = 2,
    parameter logic [NREG*WIDTH-1:0] RESET_VALUE = 32'h0000_00A5,
    parameter logic [NREG*WIDTH-1:0] RW_MASK     = 32'h0000_00FF,
    parameter logic [NREG*WIDTH-1:0] W1C_MASK    = 32'h0000_FF00,
    parameter logic [NREG*WIDTH-1:0] PULSE_MASK  = 32'h00FF_0000,
    parameter logic [NREG*WIDTH-1:0] IRQ_MASK    = 32'h0000_FF00
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  upen,
    input  logic                  upws,
    input  logic                  uprs,
    input  logic [AW-1:0]         upa,
    input  logic [WIDTH-1:0]      updi,
    output logic [WIDTH-1:0]      updo,
    output logic                  upack,
    input  logic [NREG*WIDTH-1:0] hw_in,
    output logic [NREG*WIDTH-1:0] out,
    output logic                  irq
);

    logic             wr_s;
    logic             rd_s;
    logic             hit_s;
    logic [NREG-1:0]  we_s;
    logic [WIDTH-1:0] rdata_s;
    logic [WIDTH-1:0] updo_d;
    logic [WIDTH-1:0] updo_q;
    logic             upack_d;
    logic             upack_q;
    logic             irq_d;
    logic             irq_q;

    for (genvar r = 0; r < NREG; r++) begin : g_reg
        pcfg_reg #(
            .WIDTH      (WIDTH),
            .RESET_VALUE(RESET_VALUE[r*WIDTH +: WIDTH]),
            .RW_MASK    (RW_MASK[r*WIDTH +: WIDTH]),
            .W1C_MASK   (W1C_MASK[r*WIDTH +: WIDTH]),
            .PULSE_MASK (PULSE_MASK[r*WIDTH +: WIDTH])
        ) u_reg (
            .clk  (clk),
            .rst  (rst),
            .we   (we_s[r]),
            .wd   (updi),
            .hw_in(hw_in[r*WIDTH +: WIDTH]),
            .val  (out[r*WIDTH +: WIDTH])
        );
    end

    // Address decode and read mux; unmapped addresses hit nothing and read as zero.
    always_comb begin
        wr_s    = upen & upws;
        rd_s    = upen & uprs & ~upws;
        hit_s   = 1'b0;
        we_s    = {NREG{1'b0}};
        rdata_s = {WIDTH{1'b0}};
        for (int r = 0; r < NREG; r++) begin
            if (upa == AW'(r)) begin
                hit_s   = 1'b1;
                we_s[r] = wr_s;
                rdata_s = out[r*WIDTH +: WIDTH];
            end else begin
                we_s[r] = 1'b0;
            end
        end
        if (rd_s && hit_s) begin
            updo_d = rdata_s;
        end else begin
            updo_d = {WIDTH{1'b0}};
        end
        upack_d = upen & (upws | uprs);
        irq_d   = |(out & W1C_MASK & IRQ_MASK);
    end

    // Registered port response and interrupt.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            updo_q  <= {WIDTH{1'b0}};
            upack_q <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            updo_q  <= updo_d;
            upack_q <= upack_d;
            irq_q   <= irq_d;
        end
    end

    assign updo  = updo_q;
    assign upack = upack_q;
    assign irq   = irq_q;

endmodule

// File: tb/tb_pcfg_bank.sv
// Self-checking bench for pcfg_bank: directed vector table, multi-cycle corner
// sequences, a 3-register instance for unmapped addresses, and random traffic.
module tb_pcfg_bank;

    localparam logic [31:0] RW_M  = 32'h0000_00FF;
    localparam logic [31:0] W1C_M = 32'h0000_FF00;
    localparam logic [31:0] PL_M  = 32'h00FF_0000;
    localparam logic [31:0] IRQ_M = 32'h0000_FF00;
    localparam logic [31:0] RST_V = 32'h0000_00A5;
    localparam logic [31:0] RO_M  = ~(RW_M | W1C_M | PL_M);

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        upen, upws, uprs;
    logic [1:0]  upa;
    logic [7:0]  updi;
    logic [7:0]  updo;
    logic        upack;
    logic [31:0] hw_in;
    logic [31:0] out;
    logic        irq;
    logic [7:0]  updo2;
    logic        upack2;
    logic [23:0] out2;
    logic        irq2;

    int n_checks = 0;
    int n_err    = 0;

    logic [31:0] m_st;
    logic [7:0]  m_updo;
    logic        m_ack, m_irq;

    always #5 clk = ~clk;

    pcfg_bank dut (
        .clk(clk), .rst(rst), .upen(upen), .upws(upws), .uprs(uprs), .upa(upa),
        .updi(updi), .updo(updo), .upack(upack), .hw_in(hw_in), .out(out), .irq(irq)
    );

    pcfg_bank #(
        .WIDTH(8), .NREG(3), .AW(2),
        .RESET_VALUE(24'h00_00A5), .RW_MASK(24'h00_00FF), .W1C_MASK(24'h00_FF00),
        .PULSE_MASK(24'hFF_0000), .IRQ_MASK(24'h00_FF00)
    ) dut3 (
        .clk(clk), .rst(rst), .upen(upen), .upws(upws), .uprs(uprs), .upa(upa),
        .updi(updi), .updo(updo2), .upack(upack2), .hw_in(hw_in[23:0]), .out(out2), .irq(irq2)
    );

    typedef struct {
        logic        en, ws, rs;
        logic [1:0]  a;
        logic [7:0]  di;
        logic [31:0] hw;
        logic [7:0]  e_updo;
        logic        e_ack;
        logic [31:0] e_out;
        logic        e_irq;
    } vec_t;

    vec_t vecs[17];

    function automatic vec_t mk(input logic en, input logic ws, input logic rs, input logic [1:0] a,
                                input logic [7:0] di, input logic [31:0] hw, input logic [7:0] e_updo,
                                input logic e_ack, input logic [31:0] e_out, input logic e_irq);
        vec_t v;
        v.en = en; v.ws = ws; v.rs = rs; v.a = a; v.di = di; v.hw = hw;
        v.e_updo = e_updo; v.e_ack = e_ack; v.e_out = e_out; v.e_irq = e_irq;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic en, input logic ws, input logic rs, input logic [1:0] a,
                         input logic [7:0] di, input logic [31:0] hw);
        upen = en; upws = ws; uprs = rs; upa = a; updi = di; hw_in = hw;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called just after a clock edge; reset is pulsed well before the next edge.
    task automatic do_reset();
        drive(1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 32'h0);
        rst = 1'b1;
        #2;
        chk("reset_out", out, RST_V);
        chk("reset_updo", {24'h0, updo}, 32'h0);
        chk("reset_upack", {31'h0, upack}, 32'h0);
        chk("reset_irq", {31'h0, irq}, 32'h0);
        rst = 1'b0;
        m_st = RST_V & RW_M;
        m_updo = 8'h00; m_ack = 1'b0; m_irq = 1'b0;
    endtask

    // Reference model: whole-vector rules from the register map, then one clock.
    task automatic tick_model();
        logic [31:0] wm, wd, cur, nst;
        logic [7:0]  nupdo;
        logic        nack, nirq;
        int          sh;
        sh  = int'(upa) * 8;
        wm  = 32'h0;
        if (upen && upws) wm = 32'h0000_00FF << sh;
        wd  = ({24'h0, updi} << sh) & wm;
        cur = (m_st & ~RO_M) | (hw_in & RO_M);
        nst = (((m_st & ~wm) | wd) & RW_M) | (((m_st & ~wd) | hw_in) & W1C_M) | (wd & PL_M);
        nupdo = 8'h00;
        if (upen && uprs && !upws) nupdo = cur[sh +: 8];
        nack = upen && (upws || uprs);
        nirq = |(m_st & W1C_M & IRQ_M);
        tick();
        m_st = nst; m_updo = nupdo; m_ack = nack; m_irq = nirq;
        chk("rand_out", out, (m_st & ~RO_M) | (hw_in & RO_M));
        chk("rand_updo", {24'h0, updo}, {24'h0, m_updo});
        chk("rand_upack", {31'h0, upack}, {31'h0, m_ack});
        chk("rand_irq", {31'h0, irq}, {31'h0, m_irq});
    endtask

    initial begin
        vecs[0]  = mk(1'b1, 1'b0, 1'b1, 2'd0, 8'h00, 32'h5A00_0000, 8'hA5, 1'b1, 32'h5A00_00A5, 1'b0);
        vecs[1]  = mk(1'b1, 1'b0, 1'b1, 2'd1, 8'h00, 32'h5A00_0000, 8'h00, 1'b1, 32'h5A00_00A5, 1'b0);
        vecs[2]  = mk(1'b1, 1'b0, 1'b1, 2'd2, 8'h00, 32'h5A00_0000, 8'h00, 1'b1, 32'h5A00_00A5, 1'b0);
        vecs[3]  = mk(1'b1, 1'b0, 1'b1, 2'd3, 8'h00, 32'h5A00_0000, 8'h5A, 1'b1, 32'h5A00_00A5, 1'b0);
        vecs[4]  = mk(1'b1, 1'b1, 1'b0, 2'd0, 8'h3C, 32'h0, 8'h00, 1'b1, 32'h0000_003C, 1'b0);
        vecs[5]  = mk(1'b1, 1'b0, 1'b1, 2'd0, 8'h00, 32'h0, 8'h3C, 1'b1, 32'h0000_003C, 1'b0);
        vecs[6]  = mk(1'b1, 1'b1, 1'b0, 2'd3, 8'hFF, 32'h0, 8'h00, 1'b1, 32'h0000_003C, 1'b0);
        vecs[7]  = mk(1'b1, 1'b1, 1'b1, 2'd0, 8'h11, 32'h0, 8'h00, 1'b1, 32'h0000_0011, 1'b0);
        vecs[8]  = mk(1'b0, 1'b1, 1'b1, 2'd0, 8'hFF, 32'h0, 8'h00, 1'b0, 32'h0000_0011, 1'b0);
        vecs[9]  = mk(1'b1, 1'b0, 1'b0, 2'd0, 8'hFF, 32'h0, 8'h00, 1'b0, 32'h0000_0011, 1'b0);
        vecs[10] = mk(1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 32'h0000_0200, 8'h00, 1'b0, 32'h0000_0211, 1'b0);
        vecs[11] = mk(1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 32'h0, 8'h00, 1'b0, 32'h0000_0211, 1'b1);
        vecs[12] = mk(1'b1, 1'b1, 1'b0, 2'd1, 8'h02, 32'h0, 8'h00, 1'b1, 32'h0000_0011, 1'b1);
        vecs[13] = mk(1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 32'h0, 8'h00, 1'b0, 32'h0000_0011, 1'b0);
        vecs[14] = mk(1'b1, 1'b1, 1'b0, 2'd2, 8'h81, 32'h0, 8'h00, 1'b1, 32'h0081_0011, 1'b0);
        vecs[15] = mk(1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 32'h0, 8'h00, 1'b0, 32'h0000_0011, 1'b0);
        vecs[16] = mk(1'b1, 1'b1, 1'b0, 2'd2, 8'h00, 32'h0, 8'h00, 1'b1, 32'h0000_0011, 1'b0);

        #1;
        do_reset();

        // Three-register instance: address 3 is unmapped.
        drive(1'b1, 1'b0, 1'b1, 2'd3, 8'h00, 32'h0);
        tick();
        chk("nreg3_rd_updo", {24'h0, updo2}, 32'h0);
        chk("nreg3_rd_upack", {31'h0, upack2}, 32'h1);
        drive(1'b1, 1'b1, 1'b0, 2'd3, 8'hFF, 32'h0);
        tick();
        chk("nreg3_wr_upack", {31'h0, upack2}, 32'h1);
        drive(1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 32'h0);
        tick();
        chk("nreg3_wr_out", {8'h0, out2}, 32'h0000_00A5);
        chk("nreg3_upack_drop", {31'h0, upack2}, 32'h0);

        do_reset();
        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].en, vecs[i].ws, vecs[i].rs, vecs[i].a, vecs[i].di, vecs[i].hw);
            tick();
            chk($sformatf("vec%0d_updo", i), {24'h0, updo}, {24'h0, vecs[i].e_updo});
            chk($sformatf("vec%0d_upack", i), {31'h0, upack}, {31'h0, vecs[i].e_ack});
            chk($sformatf("vec%0d_out", i), out, vecs[i].e_out);
            chk($sformatf("vec%0d_irq", i), {31'h0, irq}, {31'h0, vecs[i].e_irq});
        end

        // Hardware set and processor clear in the same cycle: set wins.
        drive(1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 32'h0000_0200);
        tick();
        chk("w1c_set_out", out, 32'h0000_0211);
        drive(1'b1, 1'b1, 1'b0, 2'd1, 8'h02, 32'h0000_0200);
        tick();
        chk("w1c_setwins_out", out, 32'h0000_0211);
        drive(1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 32'h0);
        tick();
        chk("w1c_hold_out", out, 32'h0000_0211);
        chk("w1c_hold_irq", {31'h0, irq}, 32'h1);
        drive(1'b1, 1'b1, 1'b0, 2'd1, 8'h02, 32'h0);
        tick();
        chk("w1c_clear_out", out, 32'h0000_0011);
        drive(1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 32'h0);
        tick();
        chk("w1c_irq_fall", {31'h0, irq}, 32'h0);

        // A read during the pulse cycle sees the pulse bit.
        drive(1'b1, 1'b1, 1'b0, 2'd2, 8'h01, 32'h0);
        tick();
        drive(1'b1, 1'b0, 1'b1, 2'd2, 8'h00, 32'h0);
        tick();
        chk("pulse_read_updo", {24'h0, updo}, 32'h0000_0001);
        chk("pulse_read_out", out, 32'h0000_0011);

        // Reset asserted in the cycle a write is accepted.
        drive(1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 32'h0000_0200);
        tick();
        drive(1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 32'h0);
        tick();
        chk("midrst_pre_irq", {31'h0, irq}, 32'h1);
        drive(1'b1, 1'b1, 1'b0, 2'd0, 8'h77, 32'h0);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_out_now", out, RST_V);
        chk("midrst_irq_now", {31'h0, irq}, 32'h0);
        tick();
        chk("midrst_upack", {31'h0, upack}, 32'h0);
        chk("midrst_out", out, RST_V);
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 32'h0);
        tick();
        chk("midrst_upack_after", {31'h0, upack}, 32'h0);
        chk("midrst_out_after", out, RST_V);

        do_reset();
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom), 2'($urandom),
                  8'($urandom), $urandom & $urandom & $urandom);
            tick_model();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
